// File: rtl/hazard_stall_controller.sv
// Issue-stage RAW hazard detector: tracks DEPTH cycles of in-flight writes and stalls dependents.
// issue/stall/bubble are combinational in the presented cycle; flush overrides any hazard.
module hazard_stall_controller #(
    parameter int DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [4:0]  read_sel1,
    input  logic [4:0]  read_sel2,
    input  logic [4:0]  write_sel,
    input  logic        write_en,
    input  logic        data_src,
    input  logic        flush,
    output logic        issue,
    output logic        stall,
    output logic        bubble,
    output logic        in_stall_state,
    output logic [15:0] stall_cycles,
    output logic [15:0] stall_events
);

    typedef enum logic {RUN, STALL} state_t;

    state_t     state, state_nxt;
    logic [DEPTH-1:0] win_vld;
    logic [4:0] win_dst [DEPTH];
    logic       hit1, hit2, hazard;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (win_vld[i] && win_dst[i] == read_sel1) hit1 = 1'b1;
            if (win_vld[i] && win_dst[i] == read_sel2) hit2 = 1'b1;
        end
        if (read_sel1 == 5'd0) hit1 = 1'b0;
        if (read_sel2 == 5'd0) hit2 = 1'b0;
    end

    // Reset gates every handshake output so they drop asynchronously.
    assign hazard         = !rst && instr_valid && !flush && (hit1 || (!data_src && hit2));
    assign issue          = !rst && instr_valid && !flush && !hazard;
    assign stall          = hazard;
    assign bubble         = hazard;
    assign in_stall_state = !rst && (state == STALL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_vld <= '0;
            for (int i = 0; i < DEPTH; i++) win_dst[i] <= 5'd0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                win_vld[i] <= win_vld[i-1];
                win_dst[i] <= win_dst[i-1];
            end
            win_vld[0] <= issue && write_en && (write_sel != 5'd0);
            win_dst[0] <= write_sel;
            if (flush) win_vld <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (hazard)  state_nxt = STALL;
            STALL:   if (!hazard) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        if (flush) state_nxt = RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 16'd0;
            stall_events <= 16'd0;
        end else begin
            if (hazard && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (hazard && state == RUN && stall_events != 16'hFFFF)
                stall_events <= stall_events + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized bench for hazard_stall_controller against a write-history reference model.
module tb_hazard_stall_controller;
    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [4:0]  read_sel1, read_sel2, write_sel;
    logic        write_en, data_src, flush;
    logic        issue, stall, bubble, in_stall_state;
    logic [15:0] stall_cycles, stall_events;

    int checks = 0;
    int failures = 0;
    int run_a = 0;
    logic cnt_ok = 1'b1;

    // Model: register written by each of the last DEPTH cycles (0 = nothing written).
    logic [4:0]  hist [DEPTH];
    logic        m_prev;
    logic [15:0] m_cyc, m_evt;

    hazard_stall_controller #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid),
        .read_sel1(read_sel1), .read_sel2(read_sel2), .write_sel(write_sel),
        .write_en(write_en), .data_src(data_src), .flush(flush),
        .issue(issue), .stall(stall), .bubble(bubble),
        .in_stall_state(in_stall_state),
        .stall_cycles(stall_cycles), .stall_events(stall_events)
    );

    always #5 clk = ~clk;

    function automatic logic m_hazard();
        logic h1 = 1'b0;
        logic h2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (read_sel1 != 5'd0 && hist[i] == read_sel1) h1 = 1'b1;
            if (read_sel2 != 5'd0 && hist[i] == read_sel2) h2 = 1'b1;
        end
        return !rst && instr_valid && !flush && (h1 || (!data_src && h2));
    endfunction

    function automatic logic m_issue();
        return !rst && instr_valid && !flush && !m_hazard();
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= 5'd0;
            m_prev <= 1'b0;
            m_cyc  <= 16'd0;
            m_evt  <= 16'd0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= (m_issue() && write_en) ? write_sel : 5'd0;
            if (flush) for (int i = 0; i < DEPTH; i++) hist[i] <= 5'd0;
            if (m_hazard()) begin
                if (m_cyc != 16'hFFFF) m_cyc <= m_cyc + 16'd1;
                if (!m_prev && m_evt != 16'hFFFF) m_evt <= m_evt + 16'd1;
            end
            m_prev <= m_hazard();
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_issue", {15'd0, issue}, 16'd0);
            chk("rst_stall", {15'd0, stall}, 16'd0);
            chk("rst_bubble", {15'd0, bubble}, 16'd0);
            chk("rst_in_stall", {15'd0, in_stall_state}, 16'd0);
            chk("rst_cycles", stall_cycles, 16'd0);
            chk("rst_events", stall_events, 16'd0);
        end else begin
            chk("issue", {15'd0, issue}, {15'd0, m_issue()});
            chk("stall", {15'd0, stall}, {15'd0, m_hazard()});
            chk("bubble", {15'd0, bubble}, {15'd0, m_hazard()});
            chk("in_stall", {15'd0, in_stall_state}, {15'd0, m_prev});
            chk("events", stall_events, m_evt);
            if (cnt_ok) chk("cycles", stall_cycles, m_cyc);
        end
        if (stall && !rst) run_a++;
        else               run_a = 0;
        checks++;
        if (run_a > DEPTH) begin
            failures++;
            $display("FAIL stall_len at %0t: got %0d consecutive, limit %0d", $time, run_a, DEPTH);
        end
    end

    task automatic present(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] w, input logic we, input logic ds, input logic fl);
        instr_valid = v; read_sel1 = r1; read_sel2 = r2;
        write_sel = w; write_en = we; data_src = ds; flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        present(0, 0, 0, 0, 0, 0, 0);
        repeat (DEPTH + 1) tick();
    endtask

    initial begin
        rst = 1'b1;
        present(1, 0, 0, 0, 0, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_issue_forced", {15'd0, issue}, 16'd0);
        chk("reset_in_stall", {15'd0, in_stall_state}, 16'd0);
        chk("reset_cycles", stall_cycles, 16'd0);
        chk("reset_events", stall_events, 16'd0);
        rst = 1'b0;
        present(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Write r5, then a dependent read stalls for exactly DEPTH cycles.
        present(1, 0, 0, 5, 1, 1, 0);
        chk("wr5_issue", {15'd0, issue}, 16'd1);
        tick();
        present(1, 5, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            chk("dep5_stall", {15'd0, stall}, 16'd1);
            chk("dep5_bubble", {15'd0, bubble}, 16'd1);
            chk("dep5_noissue", {15'd0, issue}, 16'd0);
            tick();
        end
        chk("dep5_issue", {15'd0, issue}, 16'd1);
        chk("dep5_nostall", {15'd0, stall}, 16'd0);
        tick();
        chk("dep5_cycles", stall_cycles, 16'd3);
        chk("dep5_events", stall_events, 16'd1);
        drain();

        // r0 is never tracked nor a hazard.
        present(1, 0, 0, 0, 1, 1, 0);
        tick();
        present(1, 0, 0, 0, 0, 0, 0);
        chk("r0_nostall", {15'd0, stall}, 16'd0);
        chk("r0_issue", {15'd0, issue}, 16'd1);
        tick();
        drain();

        // Immediate operand hides read_sel2.
        present(1, 0, 0, 7, 1, 1, 0);
        tick();
        present(1, 0, 7, 0, 0, 1, 0);
        chk("imm_nostall", {15'd0, stall}, 16'd0);
        tick();
        present(1, 0, 7, 0, 0, 0, 0);
        chk("reg2_stall", {15'd0, stall}, 16'd1);
        drain();

        // Self-dependence on the presented instruction is not a hazard.
        present(1, 11, 11, 11, 1, 0, 0);
        chk("self_nostall", {15'd0, stall}, 16'd0);
        tick();
        drain();

        // Flush wins over a hazard and empties the window.
        present(1, 0, 0, 9, 1, 1, 0);
        tick();
        present(1, 9, 0, 0, 0, 1, 1);
        chk("flush_issue", {15'd0, issue}, 16'd0);
        chk("flush_stall", {15'd0, stall}, 16'd0);
        chk("flush_bubble", {15'd0, bubble}, 16'd0);
        tick();
        present(1, 9, 0, 0, 0, 1, 0);
        chk("postflush_issue", {15'd0, issue}, 16'd1);
        chk("postflush_stall", {15'd0, stall}, 16'd0);
        tick();

        // Random stream; a stalled instruction is re-presented unchanged.
        for (int n = 0; n < 1500; n++) begin
            if (stall)
                flush = ($urandom_range(0, 19) == 0);
            else
                present($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 19) == 0);
            tick();
        end
        drain();

        // Saturation of stall_cycles, then reset in the middle of a stall.
        present(1, 0, 0, 4, 1, 1, 0);
        tick();
        present(1, 4, 0, 0, 0, 1, 0);
        cnt_ok = 1'b0;
        force dut.stall_cycles = 16'hFFFE;
        #1;
        release dut.stall_cycles;
        tick();
        tick();
        chk("sat_cycles", stall_cycles, 16'hFFFF);
        chk("sat_stall", {15'd0, stall}, 16'd1);
        chk("sat_in_stall", {15'd0, in_stall_state}, 16'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_stall", {15'd0, stall}, 16'd0);
        chk("arst_bubble", {15'd0, bubble}, 16'd0);
        chk("arst_issue", {15'd0, issue}, 16'd0);
        chk("arst_in_stall", {15'd0, in_stall_state}, 16'd0);
        chk("arst_cycles", stall_cycles, 16'd0);
        chk("arst_events", stall_events, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cnt_ok = 1'b1;
        #1;
        chk("post_rst_nostall", {15'd0, stall}, 16'd0);
        chk("post_rst_issue", {15'd0, issue}, 16'd1);
        tick();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
